wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Two-master to one-slave Wishbone classic arbiter for the Argon SoC. It lets the CPU instruction-fetch master (`if_wishbone`) and the load/store master (`lsu_wishbone`) share a single slave path, such as a unified ROM/RAM or the upstream port of `simple_wishbone_switch`. It holds the grant for a master's whole bus cycle (`cyc` high) and arbitrates round-robin or fixed-priority between cycles. An optional watchdog terminates bus cycles the slave never acknowledges.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1: 1 = alternate on contention; 0 = fixed priority, m0 always wins.
- `TIMEOUT_CYCLES`, default 255: stalled-strobe cycles before forced termination; used only with `ARB_TIMEOUT_EN`; legal range 1..65535.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `wb_m0`  `wishbone_if.slave`: master 0 (instruction fetch).
- `wb_m1`  `wishbone_if.slave`: master 1 (LSU).
- `wb_s`  `wishbone_if.master`: shared slave side.
- `gnt`  out  2: one-hot current grant (bit0 = m0, bit1 = m1); 2'b00 when idle.
- `timeout_flag`  out  1: sticky; set on any watchdog termination.

## Operation
- States (`arb_state_t`): IDLE, GRANT_M0, GRANT_M1. Reset state: IDLE.
- Arbitration decision, evaluated in IDLE and in any GRANT_Mx cycle where that master's `cyc` is low:
  - Only one `cyc` high: grant that master.
  - Both high, `ROUND_ROBIN`=1: grant the master opposite `last_grant`.
  - Both high, `ROUND_ROBIN`=0: grant m0.
  - Neither high: go to IDLE.
- Direct handoff: GRANT_M0 with `cyc0`=0 and `cyc1`=1 goes straight to GRANT_M1, with no IDLE bubble.
- While GRANT_Mx, the state holds as long as `cyc_x`=1, even if the other master requests. There is no preemption.
- `last_grant` updates on every entry into a GRANT state. Reset value is 1, so m0 wins the first tie.
- Slave-side outputs (`cyc`, `stb`, `we`, `adr`, `sel`, write data) are a combinational mux of the granted master's signals, selected by the registered state.
- In IDLE, all slave-side outputs are driven to 0.
- Slave `ack` and read data route only to the granted master. The non-granted master sees `ack`=0 and stays stalled on its own `stb`.
- Reset (asynchronous, may occur mid-cycle):
  - state → IDLE; `gnt`=0.
  - All slave-side outputs and both master `ack`s → 0.
  - `last_grant`=1; watchdog counter=0; `timeout_flag`=0.

## Timing
- Grant latency: a request that finds the arbiter in IDLE at edge N is granted at N+1. The slave sees `stb` from cycle N+1.
- Added latency once granted: 0 cycles. `ack` passes combinationally from slave to master.
- Handoff: the first cycle with `cyc0` low is the arbitration cycle. m1's `stb` reaches the slave on the next cycle.
- `gnt` is registered and equals the state encoding.
- Watchdog counter behaviour:
  - Increments each cycle that the granted `stb`=1 and slave `ack`=0.
  - Clears on slave `ack`, on `cyc` drop, and on grant change.
- Watchdog timeout, when the count reaches `TIMEOUT_CYCLES`, in that cycle:
  - The arbiter drives `ack`=1 to the granted master with read data `TIMEOUT_DATA` (32'hDEADBEEF).
  - It forces slave `stb`=0.
  - It sets `timeout_flag`.
- A slave `ack` in the same cycle the count reaches `TIMEOUT_CYCLES`: the real `ack` wins, no timeout is recorded, and the counter clears.
- Counter width is 16 bits. The count saturates and never wraps.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The watchdog is instantiated and behaves as in Timing.
  - `timeout_flag` is live and cleared only by `reset`.
- `ARB_TIMEOUT_EN` undefined:
  - No counter logic is built.
  - `timeout_flag` is tied 0.
  - A stalled slave stalls the granted master indefinitely.

## Structure
- Package `wb_arb_pkg`:
  - `arb_state_t` enum.
  - `TIMEOUT_DATA` constant.
  - Counter width localparam `WDT_W`=16.
- Sub-module `wb_arb_watchdog`:
  - Inputs: `clk`, `reset`, `stb`, `ack`, `clr`.
  - Output: one-cycle `expire` pulse.
  - Generated only under `ARB_TIMEOUT_EN`.

## Test plan
- m0 alone, single read at 0x100, slave acks 2 cycles after `stb`:
  - `gnt`=01 one cycle after `cyc0` rises.
  - m0 receives `ack` and slave data.
  - `gnt`=00 after `cyc0` drops.
- Both masters raise `cyc` in the same cycle after reset, `ROUND_ROBIN`=1:
  - m0 is served first; m1 is granted on the cycle after `cyc0` drops (direct handoff).
  - On the next tie, m1 wins.
- Same tie with `ROUND_ROBIN`=0, over three repetitions: m0 wins every tie.
- m1 holds `cyc` across 4 back-to-back writes while m0 requests:
  - m0 sees `ack`=0 throughout.
  - Slave sees only m1's `adr`/`we`/`sel`.
- `ARB_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=8, slave never acks an m0 read:
  - Exactly 8 stalled cycles.
  - m0 gets `ack` with data 32'hDEADBEEF.
  - `timeout_flag`=1 and stays 1.
- Async `reset` asserted mid-transfer while `gnt`=10:
  - Immediately: `gnt`=00, slave `cyc`/`stb`=0, and all `ack`s=0.
  - After release: the first tie goes to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter and its watchdog.
package wb_arb_pkg;

    localparam int unsigned WDT_W        = 16;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_M0 = 2'b01,
        GRANT_M1 = 2'b10
    } arb_state_t;

    function automatic arb_state_t arb_pick(logic cyc0, logic cyc1, logic last_grant,
                                            logic round_robin);
        if (cyc0 && cyc1) begin
            return (round_robin && !last_grant) ? GRANT_M1 : GRANT_M0;
        end else if (cyc0) begin
            return GRANT_M0;
        end else if (cyc1) begin
            return GRANT_M1;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Wishbone classic bus bundle; master modport drives the request, slave modport responds.
interface wishbone_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);

endinterface

// File: rtl/wb_arb_watchdog.sv
// Stall counter for the granted strobe; pulses expire once TIMEOUT_CYCLES stalled cycles elapse.
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic expire
);

    localparam logic [WDT_W-1:0] Limit = WDT_W'(TIMEOUT_CYCLES);

    logic [WDT_W-1:0] cnt_q, cnt_d;

    // A real ack always beats the watchdog.
    assign expire = stb && !ack && (cnt_q >= Limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || ack || expire) begin
            cnt_d = '0;
        end else if (stb && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter, grant held for a whole cyc.
// Define ARB_TIMEOUT_EN to build the watchdog that terminates unacknowledged strobes.
module wishbone_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    wishbone_if.slave  wb_m0,
    wishbone_if.slave  wb_m1,
    wishbone_if.master wb_s,
    output logic [1:0] gnt,
    output logic       timeout_flag
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       sel_cyc;
    logic       sel_stb;
    logic       expire;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            GRANT_M0: begin
                if (!wb_m0.cyc) begin
                    state_d = arb_pick(wb_m0.cyc, wb_m1.cyc, last_grant_q, ROUND_ROBIN != 0);
                end
            end
            GRANT_M1: begin
                if (!wb_m1.cyc) begin
                    state_d = arb_pick(wb_m0.cyc, wb_m1.cyc, last_grant_q, ROUND_ROBIN != 0);
                end
            end
            default: state_d = arb_pick(wb_m0.cyc, wb_m1.cyc, last_grant_q, ROUND_ROBIN != 0);
        endcase
        if ((state_d != state_q) && (state_d != IDLE)) begin
            last_grant_d = (state_d == GRANT_M1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt = state_q;

    // Kept apart from the bus mux so the watchdog sees the raw strobe.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        unique case (state_q)
            GRANT_M0: begin
                sel_cyc = wb_m0.cyc;
                sel_stb = wb_m0.stb;
            end
            GRANT_M1: begin
                sel_cyc = wb_m1.cyc;
                sel_stb = wb_m1.stb;
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_s.cyc    = 1'b0;
        wb_s.stb    = 1'b0;
        wb_s.we     = 1'b0;
        wb_s.adr    = '0;
        wb_s.sel    = '0;
        wb_s.dat_w  = '0;
        wb_m0.ack   = 1'b0;
        wb_m0.dat_r = '0;
        wb_m1.ack   = 1'b0;
        wb_m1.dat_r = '0;
        unique case (state_q)
            GRANT_M0: begin
                wb_s.cyc    = wb_m0.cyc;
                wb_s.stb    = wb_m0.stb && !expire;
                wb_s.we     = wb_m0.we;
                wb_s.adr    = wb_m0.adr;
                wb_s.sel    = wb_m0.sel;
                wb_s.dat_w  = wb_m0.dat_w;
                wb_m0.ack   = wb_s.ack || expire;
                wb_m0.dat_r = expire ? TIMEOUT_DATA : wb_s.dat_r;
            end
            GRANT_M1: begin
                wb_s.cyc    = wb_m1.cyc;
                wb_s.stb    = wb_m1.stb && !expire;
                wb_s.we     = wb_m1.we;
                wb_s.adr    = wb_m1.adr;
                wb_s.sel    = wb_m1.sel;
                wb_s.dat_w  = wb_m1.dat_w;
                wb_m1.ack   = wb_s.ack || expire;
                wb_m1.dat_r = expire ? TIMEOUT_DATA : wb_s.dat_r;
            end
            default: ;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    logic timeout_flag_q;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .stb   (sel_stb),
        .ack   (wb_s.ack),
        .clr   (!sel_cyc),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_flag_q <= 1'b0;
        end else if (expire) begin
            timeout_flag_q <= 1'b1;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Random and directed checks of wishbone_arbiter (round-robin and fixed-priority instances)
// against a cycle-level reference model of the grant rules.
module tb_wishbone_arbiter;

    localparam int unsigned T = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        cyc_in[2], stb_in[2], we_in[2];
    logic [31:0] adr_in[2], dw_in[2];
    logic [3:0]  sel_in[2];
    logic        s_ack_in;
    logic [31:0] s_dr_in;

    wishbone_if m0_a(), m1_a(), s_a(), m0_b(), m1_b(), s_b();

    always_comb begin
        m0_a.cyc = cyc_in[0]; m0_a.stb = stb_in[0]; m0_a.we = we_in[0];
        m0_a.adr = adr_in[0]; m0_a.sel = sel_in[0]; m0_a.dat_w = dw_in[0];
        m1_a.cyc = cyc_in[1]; m1_a.stb = stb_in[1]; m1_a.we = we_in[1];
        m1_a.adr = adr_in[1]; m1_a.sel = sel_in[1]; m1_a.dat_w = dw_in[1];
        m0_b.cyc = cyc_in[0]; m0_b.stb = stb_in[0]; m0_b.we = we_in[0];
        m0_b.adr = adr_in[0]; m0_b.sel = sel_in[0]; m0_b.dat_w = dw_in[0];
        m1_b.cyc = cyc_in[1]; m1_b.stb = stb_in[1]; m1_b.we = we_in[1];
        m1_b.adr = adr_in[1]; m1_b.sel = sel_in[1]; m1_b.dat_w = dw_in[1];
        s_a.ack = s_ack_in; s_a.dat_r = s_dr_in;
        s_b.ack = s_ack_in; s_b.dat_r = s_dr_in;
    end

    logic [1:0] gnt_a, gnt_b;
    logic       tf_a, tf_b;

    wishbone_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(T)) dut_rr (
        .clk(clk), .reset(reset), .wb_m0(m0_a), .wb_m1(m1_a), .wb_s(s_a),
        .gnt(gnt_a), .timeout_flag(tf_a)
    );

    wishbone_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(T)) dut_fp (
        .clk(clk), .reset(reset), .wb_m0(m0_b), .wb_m1(m1_b), .wb_s(s_b),
        .gnt(gnt_b), .timeout_flag(tf_b)
    );

    logic [1:0]  o_gnt[2];
    logic        o_tf[2], o_cyc[2], o_stb[2], o_we[2];
    logic [31:0] o_adr[2], o_dw[2];
    logic [3:0]  o_sel[2];
    logic        o_ack[2][2];
    logic [31:0] o_dr[2][2];

    always_comb begin
        o_gnt[0] = gnt_a; o_tf[0] = tf_a; o_gnt[1] = gnt_b; o_tf[1] = tf_b;
        o_cyc[0] = s_a.cyc; o_stb[0] = s_a.stb; o_we[0] = s_a.we;
        o_adr[0] = s_a.adr; o_sel[0] = s_a.sel; o_dw[0] = s_a.dat_w;
        o_cyc[1] = s_b.cyc; o_stb[1] = s_b.stb; o_we[1] = s_b.we;
        o_adr[1] = s_b.adr; o_sel[1] = s_b.sel; o_dw[1] = s_b.dat_w;
        o_ack[0][0] = m0_a.ack; o_ack[0][1] = m1_a.ack; o_dr[0][0] = m0_a.dat_r;
        o_dr[0][1] = m1_a.dat_r; o_ack[1][0] = m0_b.ack; o_ack[1][1] = m1_b.ack;
        o_dr[1][0] = m0_b.dat_r; o_dr[1][1] = m1_b.dat_r;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: owner 0 = nobody, 1 = m0, 2 = m1; last = index of last master granted.
    int owner[2], last[2], cnt[2];
    bit flag[2];
    bit ack_seen[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = 0; last[i] = 1; cnt[i] = 0; flag[i] = 1'b0;
        end
        ack_seen[0] = 1'b0; ack_seen[1] = 1'b0;
    endtask

    task automatic compare_and_advance();
        for (int i = 0; i < 2; i++) begin
            int    k, nxt;
            bit    c, s, exp_t, e_ack;
            string nm;
            nm    = (i == 0) ? "rr" : "fp";
            k     = (owner[i] == 0) ? 0 : owner[i] - 1;
            c     = (owner[i] != 0) && cyc_in[k];
            s     = (owner[i] != 0) && stb_in[k];
            exp_t = 1'b0;
`ifdef ARB_TIMEOUT_EN
            exp_t = s && !s_ack_in && (cnt[i] >= int'(T));
`endif
            check({nm, " gnt"}, 32'(o_gnt[i]), (owner[i] == 0) ? 0 : 32'(owner[i]));
            check({nm, " s_cyc"}, 32'(o_cyc[i]), 32'(c));
            check({nm, " s_stb"}, 32'(o_stb[i]), 32'(s && !exp_t));
            check({nm, " s_we"}, 32'(o_we[i]), (owner[i] == 0) ? 0 : 32'(we_in[k]));
            check({nm, " s_adr"}, o_adr[i], (owner[i] == 0) ? 0 : adr_in[k]);
            check({nm, " s_sel"}, 32'(o_sel[i]), (owner[i] == 0) ? 0 : 32'(sel_in[k]));
            check({nm, " s_dat_w"}, o_dw[i], (owner[i] == 0) ? 0 : dw_in[k]);
            for (int m = 0; m < 2; m++) begin
                e_ack = (owner[i] == m + 1) && (s_ack_in || exp_t);
                check($sformatf("%s m%0d ack", nm, m), 32'(o_ack[i][m]), 32'(e_ack));
                if (e_ack) begin
                    check($sformatf("%s m%0d dat_r", nm, m), o_dr[i][m],
                          exp_t ? 32'hDEAD_BEEF : s_dr_in);
                end
                if (i == 0) ack_seen[m] = e_ack;
            end
            check({nm, " timeout_flag"}, 32'(o_tf[i]), 32'(flag[i]));

            if (c) nxt = owner[i];
            else if (cyc_in[0] && cyc_in[1]) nxt = (i == 0 && last[i] == 0) ? 2 : 1;
            else if (cyc_in[0]) nxt = 1;
            else if (cyc_in[1]) nxt = 2;
            else nxt = 0;
            if (!c || s_ack_in || exp_t) cnt[i] = 0;
            else if (s && cnt[i] < 65535) cnt[i]++;
            if (exp_t) flag[i] = 1'b1;
            if (nxt != 0) last[i] = nxt - 1;
            owner[i] = nxt;
        end
    endtask

    task automatic zero_inputs();
        for (int m = 0; m < 2; m++) begin
            cyc_in[m] = 1'b0; stb_in[m] = 1'b0; we_in[m] = 1'b0;
            adr_in[m] = '0; dw_in[m] = '0; sel_in[m] = '0;
        end
        s_ack_in = 1'b0; s_dr_in = '0;
    endtask

    task automatic cycle(input bit c0, input bit s0, input bit c1, input bit s1, input bit ack);
        @(posedge clk);
        #1;
        cyc_in[0] = c0; stb_in[0] = s0; cyc_in[1] = c1; stb_in[1] = s1;
        for (int m = 0; m < 2; m++) begin
            we_in[m]  = 1'($urandom_range(0, 1));
            adr_in[m] = $urandom;
            sel_in[m] = 4'($urandom);
            dw_in[m]  = $urandom;
        end
        adr_in[0] = c0 ? 32'h100 : adr_in[0];
        s_ack_in = ack;
        s_dr_in  = $urandom;
        #3;
        compare_and_advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        zero_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int pct;
        bit nc, ns;
        zero_inputs();
        model_reset();
        do_reset();

        repeat (2) cycle(0, 0, 0, 0, 0);

        // m0 single read at 0x100, ack two cycles after stb reaches the slave
        repeat (3) cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 0, 0);

        // Tie after reset then direct handoff to m1
        do_reset();
        cycle(1, 1, 1, 1, 0);
        cycle(1, 1, 1, 1, 1);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0);

        // Repeated ties where the winner finishes alone
        repeat (3) begin
            do_reset();
            cycle(1, 1, 1, 1, 0);
            cycle(1, 1, 1, 1, 1);
            cycle(0, 0, 0, 0, 0);
            repeat (2) cycle(1, 1, 1, 1, 0);
            cycle(1, 1, 1, 1, 1);
            cycle(0, 0, 0, 0, 0);
        end

        // m1 holds cyc for 4 acked beats while m0 keeps requesting
        do_reset();
        cycle(0, 0, 1, 1, 0);
        repeat (4) cycle(1, 1, 1, 1, 1);

        // Asynchronous reset in the middle of m1's cycle
        @(posedge clk);
        #1;
        s_ack_in = 1'b1;
        #1;
        check("pre-reset gnt", 32'(gnt_a), 32'h2);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async rst gnt %0d", i), 32'(o_gnt[i]), 0);
            check($sformatf("async rst cyc %0d", i), 32'(o_cyc[i]), 0);
            check($sformatf("async rst stb %0d", i), 32'(o_stb[i]), 0);
            check($sformatf("async rst ack0 %0d", i), 32'(o_ack[i][0]), 0);
            check($sformatf("async rst ack1 %0d", i), 32'(o_ack[i][1]), 0);
        end
        zero_inputs();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) cycle(1, 1, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // Slave never acks an m0 read
        do_reset();
        repeat (14) cycle(1, 1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);

        // Randomized traffic with varying slave responsiveness
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            case (blk % 3)
                0: pct = 5;
                1: pct = 30;
                default: pct = 70;
            endcase
            repeat (200) begin
                bit c[2], s[2];
                for (int m = 0; m < 2; m++) begin
                    if (cyc_in[m]) nc = ack_seen[m] ? ($urandom_range(0, 1) == 1)
                                                    : ($urandom_range(0, 15) != 0);
                    else nc = ($urandom_range(0, 2) == 0);
                    ns   = nc && ($urandom_range(0, 7) != 0);
                    c[m] = nc;
                    s[m] = ns;
                end
                cycle(c[0], s[0], c[1], s[1], $urandom_range(0, 99) < pct);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
